// File: rtl/unified_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// unified_mem_ctrl_if
//   Bundles the pipeline-side request/response signals and the shared-memory
//   port of the unified memory controller.
//   slave  : the controller (takes IF/MEM requests and memory read data,
//            drives responses and memory strobes)
//   master : the surrounding pipeline stages plus the memory
// Signals
//   if_req/if_addr         -> fetch request, held until if_ready
//   if_ready/if_inst/if_err <- fetch response
//   dm_req/dm_we/dm_funct3/dm_addr/dm_wdata -> data request, held until dm_ready
//   dm_ready/dm_rdata/dm_err <- data response
//   busy                   <- access in progress (hazard unit)
//   mem_is_inst/mem_read/mem_write/mem_funct3/mem_addr/mem_wdata <- memory port
//   mem_inst_in/mem_data_in -> memory read data (combinational)
// ---------------------------------------------------------------------------
interface unified_mem_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_inst;
   logic              if_err;

   logic              dm_req;
   logic              dm_we;
   logic [2:0]        dm_funct3;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ready;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_err;

   logic              busy;

   logic              mem_is_inst;
   logic              mem_read;
   logic              mem_write;
   logic [2:0]        mem_funct3;
   logic [ADDR_W:0]   mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_inst_in;
   logic [DATA_W-1:0] mem_data_in;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
      input  mem_inst_in, mem_data_in,
      output if_ready, if_inst, if_err,
      output dm_ready, dm_rdata, dm_err,
      output busy,
      output mem_is_inst, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
      output mem_inst_in, mem_data_in,
      input  if_ready, if_inst, if_err,
      input  dm_ready, dm_rdata, dm_err,
      input  busy,
      input  mem_is_inst, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_ctrl.sv
// ---------------------------------------------------------------------------
// unified_mem_ctrl
//   Initiator side of the single shared instruction/data memory. Arbitrates
//   fetch and load/store requests (data wins), issues one access at a time
//   and registers the returned word for the requesting stage.
// Ports
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : unified_mem_ctrl_if.slave (IF port, MEM port, busy, memory port)
// ---------------------------------------------------------------------------
module unified_mem_ctrl #(
   parameter int                ADDR_W = 8,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] NOP    = 32'h00000033
) (
   input logic                clk,
   input logic                rst,
   unified_mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

   state_t            r_state;
   logic              r_served_dm;   // which port the current access belongs to
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [DATA_W-1:0] r_wdata;
   logic              r_if_ready;
   logic              r_if_err;
   logic [DATA_W-1:0] r_if_inst;
   logic              r_dm_ready;
   logic              r_dm_err;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              r_busy;

   logic              w_aligned;
   logic              w_take_dm;
   logic              w_take_if;

   // Word needs addr[1:0]==0, half needs addr[0]==0, bytes are always fine.
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b10:   return (a == 2'b00);
         2'b01:   return ~a[0];
         default: return 1'b1;
      endcase
   endfunction

   // Fetches are latched as word accesses, so one check covers both ports.
   assign w_aligned = is_aligned(r_funct3, r_addr[1:0]);

   // In RESP only the port that was not just served may start an access;
   // the served requester is still dropping its req this cycle.
   assign w_take_dm = bus.dm_req &
                      ((r_state == S_IDLE) | ((r_state == S_RESP) & ~r_served_dm));
   assign w_take_if = bus.if_req & ~w_take_dm &
                      (((r_state == S_IDLE) & ~bus.dm_req) |
                       ((r_state == S_RESP) & r_served_dm));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_served_dm <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_wdata     <= '0;
         r_if_ready  <= 1'b0;
         r_if_err    <= 1'b0;
         r_if_inst   <= NOP;
         r_dm_ready  <= 1'b0;
         r_dm_err    <= 1'b0;
         r_dm_rdata  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_if_ready <= 1'b0;
         r_if_err   <= 1'b0;
         r_dm_ready <= 1'b0;
         r_dm_err   <= 1'b0;

         case (r_state)
            S_FETCH: begin
               if (w_aligned) r_if_inst <= bus.mem_inst_in;
               r_if_ready <= 1'b1;
               r_if_err   <= ~w_aligned;
               r_busy     <= 1'b0;
               r_state    <= S_RESP;
            end
            S_DATA: begin
               if (w_aligned && !r_we) r_dm_rdata <= bus.mem_data_in;
               r_dm_ready <= 1'b1;
               r_dm_err   <= ~w_aligned;
               r_busy     <= 1'b0;
               r_state    <= S_RESP;
            end
            default: begin
               // IDLE and RESP share the request-acceptance path.
               if (w_take_dm) begin
                  r_addr      <= bus.dm_addr;
                  r_we        <= bus.dm_we;
                  r_funct3    <= bus.dm_funct3;
                  r_wdata     <= bus.dm_wdata;
                  r_served_dm <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_DATA;
               end else if (w_take_if) begin
                  r_addr      <= bus.if_addr;
                  r_we        <= 1'b0;
                  r_funct3    <= 3'b010;
                  r_served_dm <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_FETCH;
               end else begin
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Strobes are gated by ~rst so an access interrupted by reset never
   // writes memory in the reset cycle itself.
   assign bus.mem_is_inst = (r_state == S_FETCH) & w_aligned & ~rst;
   assign bus.mem_read    = (r_state == S_DATA) & ~r_we & w_aligned & ~rst;
   assign bus.mem_write   = (r_state == S_DATA) &  r_we & w_aligned & ~rst;
   assign bus.mem_funct3  = r_funct3;
   assign bus.mem_addr    = {1'b0, r_addr};
   assign bus.mem_wdata   = r_wdata;

   assign bus.if_ready = r_if_ready;
   assign bus.if_inst  = r_if_inst;
   assign bus.if_err   = r_if_err;
   assign bus.dm_ready = r_dm_ready;
   assign bus.dm_rdata = r_dm_rdata;
   assign bus.dm_err   = r_dm_err;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_ctrl
//   Directed bench for unified_mem_ctrl. Drivers push the expected response
//   (data, err, ready cycle) into per-port queues; a monitor pops and
//   compares whenever a ready pulse appears.
// ---------------------------------------------------------------------------
module tb_unified_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   wr_cnt = 0;
   int   rdwr_cnt = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t ifq[$];
   exp_t dq[$];

   unified_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) u_if();

   unified_mem_ctrl #(.ADDR_W(8), .DATA_W(32), .NOP(32'h00000033)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.mem_write) wr_cnt = wr_cnt + 1;
      if (u_if.mem_write || u_if.mem_read) rdwr_cnt = rdwr_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (u_if.dm_ready) begin
         if (dq.size() == 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL dm_unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
         end else begin
            e = dq.pop_front();
            check("dm_rdata", u_if.dm_rdata, e.data);
            check("dm_err", {31'b0, u_if.dm_err}, {31'b0, e.err});
            check("dm_ready_cycle", cyc, e.cyc);
         end
      end
      if (u_if.if_ready) begin
         if (ifq.size() == 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL if_unexpected_ready: got ready=1 expected no response (cycle %0d)", cyc);
         end else begin
            e = ifq.pop_front();
            check("if_inst", u_if.if_inst, e.data);
            check("if_err", {31'b0, u_if.if_err}, {31'b0, e.err});
            check("if_ready_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic if_op(input logic [7:0] a, input logic [31:0] exp_inst,
                        input logic exp_err, input int acc_off);
      int   c0;
      int   t;
      bit   done;
      exp_t e;
      @(posedge clk); #1;
      u_if.if_req  = 1'b1;
      u_if.if_addr = a;
      c0 = cyc;
      e.data = exp_inst; e.err = exp_err; e.cyc = c0 + acc_off + 1;
      ifq.push_back(e);
      t = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (cyc == c0 + acc_off) begin
            check("if_acc_busy", {31'b0, u_if.busy}, 32'd1);
            check("if_acc_addr", {23'b0, u_if.mem_addr}, {24'b0, a});
            check("if_acc_rw", {30'b0, u_if.mem_read, u_if.mem_write}, 32'd0);
            if (!exp_err) check("if_acc_is_inst", {31'b0, u_if.mem_is_inst}, 32'd1);
         end
         if (u_if.if_ready) done = 1;
         else begin
            t = t + 1;
            if (t > 20) begin
               n_checks = n_checks + 1;
               n_errors = n_errors + 1;
               $display("FAIL if_timeout: got no if_ready expected one within 20 cycles");
               done = 1;
            end
         end
      end
      u_if.if_req = 1'b0;
   endtask

   task automatic dm_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int acc_off,
                        input logic exp_rs, input logic exp_ws);
      int   c0;
      int   t;
      bit   done;
      exp_t e;
      @(posedge clk); #1;
      u_if.dm_req    = 1'b1;
      u_if.dm_we     = we;
      u_if.dm_funct3 = f3;
      u_if.dm_addr   = a;
      u_if.dm_wdata  = wd;
      c0 = cyc;
      e.data = exp_rd; e.err = exp_err; e.cyc = c0 + acc_off + 1;
      dq.push_back(e);
      t = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (cyc == c0 + acc_off) begin
            check("dm_acc_busy", {31'b0, u_if.busy}, 32'd1);
            check("dm_acc_addr", {23'b0, u_if.mem_addr}, {24'b0, a});
            check("dm_acc_funct3", {29'b0, u_if.mem_funct3}, {29'b0, f3});
            check("dm_acc_wdata", u_if.mem_wdata, wd);
            check("dm_acc_strobes", {29'b0, u_if.mem_is_inst, u_if.mem_read, u_if.mem_write},
                  {30'b0, exp_rs, exp_ws});
         end
         if (u_if.dm_ready) done = 1;
         else begin
            t = t + 1;
            if (t > 20) begin
               n_checks = n_checks + 1;
               n_errors = n_errors + 1;
               $display("FAIL dm_timeout: got no dm_ready expected one within 20 cycles");
               done = 1;
            end
         end
      end
      u_if.dm_req = 1'b0;
   endtask

   initial begin
      int c0;
      int w0;
      exp_t e;
      u_if.if_req = 0; u_if.if_addr = 0;
      u_if.dm_req = 0; u_if.dm_we = 0; u_if.dm_funct3 = 0; u_if.dm_addr = 0; u_if.dm_wdata = 0;
      u_if.mem_inst_in = 0; u_if.mem_data_in = 0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_if_inst", u_if.if_inst, 32'h00000033);
      check("reset_busy", {31'b0, u_if.busy}, 32'd0);

      // Store interrupted by a 2-cycle reset while in DATA
      @(posedge clk); #1;
      u_if.dm_req = 1; u_if.dm_we = 1; u_if.dm_funct3 = 3'b010;
      u_if.dm_addr = 8'h10; u_if.dm_wdata = 32'h55;
      @(posedge clk); #1;
      rst = 1'b1; u_if.dm_req = 0;
      @(negedge clk);
      check("rst_mid_store_mem_write", {31'b0, u_if.mem_write}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_hold_mem_write", {31'b0, u_if.mem_write}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_if_inst", u_if.if_inst, 32'h00000033);
      check("post_rst_dm_rdata", u_if.dm_rdata, 32'd0);
      check("post_rst_flags", {26'b0, u_if.if_ready, u_if.if_err, u_if.dm_ready,
                               u_if.dm_err, u_if.busy, u_if.mem_is_inst}, 32'd0);
      check("post_rst_strobes", {30'b0, u_if.mem_read, u_if.mem_write}, 32'd0);
      check("post_rst_addr", {23'b0, u_if.mem_addr}, 32'd0);
      check("post_rst_funct3", {29'b0, u_if.mem_funct3}, 32'd0);
      check("post_rst_wdata", u_if.mem_wdata, 32'd0);
      check("post_rst_wr_cnt", wr_cnt, 32'd0);

      // Plain fetch
      u_if.mem_inst_in = 32'h00000083;
      if_op(8'h04, 32'h00000083, 1'b0, 1);

      // Simultaneous fetch and load: data first, fetch two cycles later
      u_if.mem_inst_in = 32'h12345678;
      u_if.mem_data_in = 32'd17;
      fork
         if_op(8'h08, 32'h12345678, 1'b0, 3);
         dm_op(1'b0, 3'b010, 8'h00, 32'h0, 32'd17, 1'b0, 1, 1'b1, 1'b0);
      join

      // Store: exactly one write cycle, rdata untouched
      w0 = wr_cnt;
      dm_op(1'b1, 3'b010, 8'h0C, 32'd42, 32'd17, 1'b0, 1, 1'b0, 1'b1);
      check("sw_write_cycles", wr_cnt - w0, 32'd1);

      // Misaligned loads keep rdata; byte load at odd address completes
      u_if.mem_data_in = 32'h0000DEAD;
      w0 = rdwr_cnt;
      dm_op(1'b0, 3'b010, 8'h02, 32'h0, 32'd17, 1'b1, 1, 1'b0, 1'b0);
      dm_op(1'b0, 3'b001, 8'h03, 32'h0, 32'd17, 1'b1, 1, 1'b0, 1'b0);
      check("misaligned_no_strobes", rdwr_cnt - w0, 32'd0);
      dm_op(1'b0, 3'b000, 8'h03, 32'h0, 32'h0000DEAD, 1'b0, 1, 1'b1, 1'b0);

      // Misaligned fetch keeps the previous instruction
      u_if.mem_inst_in = 32'hFFFFFFFF;
      if_op(8'h06, 32'h12345678, 1'b1, 1);

      // dm_req held across RESP: RESP -> IDLE -> DATA, 3 cycles per access
      u_if.mem_data_in = 32'h000000A5;
      @(posedge clk); #1;
      u_if.dm_req = 1; u_if.dm_we = 0; u_if.dm_funct3 = 3'b000;
      u_if.dm_addr = 8'h01; u_if.dm_wdata = 32'h0;
      c0 = cyc;
      e.data = 32'hA5; e.err = 1'b0; e.cyc = c0 + 2; dq.push_back(e);
      e.cyc = c0 + 5; dq.push_back(e);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (cyc == c0 + 3) check("hold_idle_busy", {31'b0, u_if.busy}, 32'd0);
         if (cyc == c0 + 4) begin
            check("hold_access_busy", {31'b0, u_if.busy}, 32'd1);
            check("hold_access_read", {31'b0, u_if.mem_read}, 32'd1);
         end
      end
      u_if.dm_req = 0;

      repeat (4) @(negedge clk);
      check("dm_queue_drained", dq.size(), 32'd0);
      check("if_queue_drained", ifq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
